// File: rtl/sram_device_model.sv
// Purpose : device-side model of a 32-bit async SRAM on the controller pin bus, with timing checks.
// Latency : read data driven READ_LAT cycles after a stable address is sampled; writes commit on WE_N release.
// Backpr. : none; the controller owns the bus and the model only responds or flags protocol_err.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset (array contents survive reset)
//   SRAM_ADDR         word address
//   SRAM_UB_N/LB_N    byte-lane enables (active low), honoured on writes only
//   SRAM_WE_N/CE_N/OE_N  write / chip / output enables (active low); WE_N dominates OE_N
//   SRAM_DQ           shared data bus; driven only while a read is valid, else 'z
//   rd_count/wr_count completed reads / committed writes, wrapping 16-bit counters
//   protocol_err      sticky flag: short write or address change while WE_N low
//   busy              high whenever the model is not idle
module sram_device_model #(
    parameter int                ADDR_W    = 17,
    parameter int                DATA_W    = 32,
    parameter int                READ_LAT  = 3,
    parameter int                WRITE_MIN = 2,
    parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              protocol_err,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int HALF  = DATA_W / 2;

    typedef enum logic [1:0] {S_IDLE, S_RWAIT, S_RVALID, S_WRITE} state_t;

    state_t              state;
    logic [7:0]          lcnt;
    logic [7:0]          wcnt;
    logic                poison;
    logic [ADDR_W-1:0]   raddr;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                wub_n;
    logic                wlb_n;
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic sel, wr, rd, commit;

    assign sel = !SRAM_CE_N;
    assign wr  = sel && !SRAM_WE_N;
    assign rd  = sel && SRAM_WE_N && !SRAM_OE_N;

    // Write ends on the first cycle in S_WRITE without wr; only a long-enough,
    // address-stable write reaches the array.
    assign commit = (state == S_WRITE) && !wr && (wcnt >= 8'(WRITE_MIN)) && !poison;

    assign busy = (state != S_IDLE);

    // Gating on WE_N keeps the model off the bus the moment the controller
    // starts a write, even before the state register catches up.
    assign SRAM_DQ = (state == S_RVALID && sel && SRAM_WE_N) ? mem[raddr] : 'z;

    // Power-up contents of the modelled chip; simulation-only initialisation.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = INIT_WORD;
        end
    end

    always @(posedge clk) begin
        if (!rst && commit) begin
            if (!wub_n) mem[waddr][DATA_W-1:HALF] <= wdata[DATA_W-1:HALF];
            if (!wlb_n) mem[waddr][HALF-1:0]      <= wdata[HALF-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rd_count     <= '0;
            wr_count     <= '0;
            protocol_err <= 1'b0;
            lcnt         <= '0;
            wcnt         <= '0;
            poison       <= 1'b0;
        end else if (wr && state != S_WRITE) begin
            // Any non-write state yields to a new write immediately.
            state  <= S_WRITE;
            wcnt   <= 8'd1;
            poison <= 1'b0;
            waddr  <= SRAM_ADDR;
            wdata  <= SRAM_DQ;
            wub_n  <= SRAM_UB_N;
            wlb_n  <= SRAM_LB_N;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd) begin
                        state <= S_RWAIT;
                        lcnt  <= 8'd1;
                        raddr <= SRAM_ADDR;
                    end
                end
                S_RWAIT: begin
                    if (!rd) begin
                        state <= S_IDLE;
                    end else if (SRAM_ADDR != raddr) begin
                        raddr <= SRAM_ADDR;
                        lcnt  <= 8'd1;
                    end else if (lcnt == 8'(READ_LAT)) begin
                        state    <= S_RVALID;
                        rd_count <= rd_count + 16'd1;
                    end else begin
                        lcnt <= lcnt + 8'd1;
                    end
                end
                S_RVALID: begin
                    if (!rd) begin
                        state <= S_IDLE;
                    end else if (SRAM_ADDR != raddr) begin
                        state <= S_RWAIT;
                        raddr <= SRAM_ADDR;
                        lcnt  <= 8'd1;
                    end
                end
                S_WRITE: begin
                    if (wr) begin
                        if (wcnt < 8'(WRITE_MIN)) wcnt <= wcnt + 8'd1;
                        wdata <= SRAM_DQ;
                        wub_n <= SRAM_UB_N;
                        wlb_n <= SRAM_LB_N;
                        if (SRAM_ADDR != waddr) begin
                            protocol_err <= 1'b1;
                            poison       <= 1'b1;
                        end
                    end else begin
                        if (commit) wr_count <= wr_count + 16'd1;
                        else        protocol_err <= 1'b1;
                        if (rd) begin
                            state <= S_RWAIT;
                            lcnt  <= 8'd1;
                            raddr <= SRAM_ADDR;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_device_model.sv
// Purpose : directed vector bench for sram_device_model.
// Latency : each vector is applied, one clock edge taken, outputs sampled 1 time unit later.
// Backpr. : none; the bench drives the pin bus directly and releases DQ when not writing.
module tb_sram_device_model;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce_n, we_n, oe_n, ub_n, lb_n, drv;
    logic [16:0] addr;
    logic [31:0] wdat;
    wire  [31:0] dq;
    logic [15:0] rd_count, wr_count;
    logic        protocol_err, busy;

    // The bench drives write data; an undriven bus floats to all ones.
    assign dq = drv ? wdat : 'z;
    for (genvar i = 0; i < 32; i++) begin : g_pu
        pullup (dq[i]);
    end

    localparam logic [31:0] ZV = 32'hFFFF_FFFF;

    sram_device_model dut (
        .clk          (clk),
        .rst          (rst),
        .SRAM_ADDR    (addr),
        .SRAM_UB_N    (ub_n),
        .SRAM_LB_N    (lb_n),
        .SRAM_WE_N    (we_n),
        .SRAM_CE_N    (ce_n),
        .SRAM_OE_N    (oe_n),
        .SRAM_DQ      (dq),
        .rd_count     (rd_count),
        .wr_count     (wr_count),
        .protocol_err (protocol_err),
        .busy         (busy)
    );

    typedef struct {
        string       nm;
        logic        rst, ce_n, we_n, oe_n, ub_n, lb_n, drv;
        logic [16:0] addr;
        logic [31:0] wdat;
        logic        chk_dq;
        logic [31:0] edq;
        logic [15:0] erd, ewr;
        logic        eerr, ebusy;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input string nm, input logic r, ce, we, oe, ub, lb,
                       input logic [16:0] a, input logic dr, input logic [31:0] d,
                       input logic cd, input logic [31:0] e,
                       input int erd, ewr, input logic eerr, eb);
        vec_t v;
        v.nm = nm; v.rst = r; v.ce_n = ce; v.we_n = we; v.oe_n = oe;
        v.ub_n = ub; v.lb_n = lb; v.addr = a; v.drv = dr; v.wdat = d;
        v.chk_dq = cd; v.edq = e; v.erd = 16'(erd); v.ewr = 16'(ewr);
        v.eerr = eerr; v.ebusy = eb;
        vq.push_back(v);
    endtask

    task automatic idle(input string nm, input int n, input int erd, ewr, input logic eerr);
        for (int i = 0; i < n; i++)
            add(nm, 0, 0, 1, 1, 0, 0, '0, 0, '0, 1, ZV, erd, ewr, eerr, 0);
    endtask

    // n cycles with WE_N low; DQ carries bench data so it is not checked.
    task automatic wr_seq(input string nm, input logic [16:0] a, input logic [31:0] d,
                          input logic ub, lb, oe, input int n, input int erd, ewr,
                          input logic eerr);
        for (int i = 0; i < n; i++)
            add(nm, 0, 0, 0, oe, ub, lb, a, 1, d, 0, '0, erd, ewr, eerr, 1);
    endtask

    // Three wait cycles, first valid cycle, one hold cycle, then release.
    task automatic rd_seq(input string nm, input logic [16:0] a, input logic [31:0] d,
                          input int erd, ewr, input logic eerr);
        for (int i = 0; i < 3; i++)
            add(nm, 0, 0, 1, 0, 0, 0, a, 0, '0, 1, ZV, erd, ewr, eerr, 1);
        add(nm, 0, 0, 1, 0, 0, 0, a, 0, '0, 1, d, erd + 1, ewr, eerr, 1);
        add(nm, 0, 0, 1, 0, 0, 0, a, 0, '0, 1, d, erd + 1, ewr, eerr, 1);
        add(nm, 0, 0, 1, 1, 0, 0, a, 0, '0, 1, ZV, erd + 1, ewr, eerr, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        rst = 1; ce_n = 0; we_n = 1; oe_n = 1; ub_n = 0; lb_n = 0;
        drv = 0; addr = '0; wdat = '0;

        // reset
        for (int i = 0; i < 2; i++)
            add("reset", 1, 0, 1, 1, 0, 0, '0, 0, '0, 1, ZV, 0, 0, 0, 0);

        // 1: full write then read with latency 3
        wr_seq("t1_wr", 17'h10, 32'hDEAD_BEEF, 0, 0, 1, 5, 0, 0, 0);
        idle("t1_commit", 1, 0, 1, 0);
        rd_seq("t1_rd", 17'h10, 32'hDEAD_BEEF, 0, 1, 0);

        // 2: lower lane only
        wr_seq("t2_wr", 17'h10, 32'h1234_5678, 1, 0, 1, 5, 1, 1, 0);
        idle("t2_commit", 1, 1, 2, 0);
        rd_seq("t2_rd", 17'h10, 32'hDEAD_5678, 1, 2, 0);

        // 3: one-cycle write is too short
        wr_seq("t3_wr", 17'h20, 32'h5555_5555, 0, 0, 1, 1, 2, 2, 0);
        idle("t3_short", 1, 2, 2, 1);
        rd_seq("t3_rd", 17'h20, 32'h0000_0000, 2, 2, 1);

        // 4: address switch mid-latency restarts the count
        wr_seq("t4_wr", 17'h20, 32'h0A0B_0C0D, 0, 0, 1, 5, 3, 2, 1);
        idle("t4_commit", 1, 3, 3, 1);
        for (int i = 0; i < 2; i++)
            add("t4_rd10", 0, 0, 1, 0, 0, 0, 17'h10, 0, '0, 1, ZV, 3, 3, 1, 1);
        for (int i = 0; i < 3; i++)
            add("t4_rd20", 0, 0, 1, 0, 0, 0, 17'h20, 0, '0, 1, ZV, 3, 3, 1, 1);
        add("t4_valid", 0, 0, 1, 0, 0, 0, 17'h20, 0, '0, 1, 32'h0A0B_0C0D, 4, 3, 1, 1);
        add("t4_hold",  0, 0, 1, 0, 0, 0, 17'h20, 0, '0, 1, 32'h0A0B_0C0D, 4, 3, 1, 1);
        idle("t4_rel", 1, 4, 3, 1);

        // 5: reset in the middle of a write discards it
        wr_seq("t5_wr", 17'h10, 32'hCAFE_F00D, 0, 0, 1, 2, 4, 3, 1);
        add("t5_rst", 1, 0, 0, 1, 0, 0, 17'h10, 1, 32'hCAFE_F00D, 0, '0, 0, 0, 0, 0);
        idle("t5_post", 1, 0, 0, 0);
        rd_seq("t5_rd", 17'h10, 32'hDEAD_5678, 0, 0, 0);

        // 6: chip deselected keeps bus released
        for (int i = 0; i < 10; i++)
            add("t6_ce", 0, 1, 1, 0, 0, 0, 17'h10, 0, '0, 1, ZV, 1, 0, 0, 0);

        // 7: WRITE_MIN-length write with OE_N low, then read-after-write
        wr_seq("t7_wr", 17'h30, 32'h1122_3344, 0, 0, 0, 2, 1, 0, 0);
        add("t7_raw", 0, 0, 1, 0, 0, 0, 17'h30, 0, '0, 1, ZV, 1, 1, 0, 1);
        for (int i = 0; i < 2; i++)
            add("t7_wait", 0, 0, 1, 0, 0, 0, 17'h30, 0, '0, 1, ZV, 1, 1, 0, 1);
        add("t7_valid", 0, 0, 1, 0, 0, 0, 17'h30, 0, '0, 1, 32'h1122_3344, 2, 1, 0, 1);
        idle("t7_rel", 1, 2, 1, 0);

        // 8: address change while WE_N low poisons the write
        add("t8_w0", 0, 0, 0, 1, 0, 0, 17'h40, 1, 32'h9999_9999, 0, '0, 2, 1, 0, 1);
        add("t8_w1", 0, 0, 0, 1, 0, 0, 17'h41, 1, 32'h9999_9999, 0, '0, 2, 1, 1, 1);
        add("t8_w2", 0, 0, 0, 1, 0, 0, 17'h41, 1, 32'h9999_9999, 0, '0, 2, 1, 1, 1);
        idle("t8_end", 1, 2, 1, 1);
        rd_seq("t8_rd", 17'h40, 32'h0000_0000, 2, 1, 1);

        for (int i = 0; i < vq.size(); i++) begin
            rst  = vq[i].rst;  ce_n = vq[i].ce_n; we_n = vq[i].we_n;
            oe_n = vq[i].oe_n; ub_n = vq[i].ub_n; lb_n = vq[i].lb_n;
            addr = vq[i].addr; drv  = vq[i].drv;  wdat = vq[i].wdat;
            @(posedge clk);
            #1;
            chk({vq[i].nm, ".rd_count"}, 32'(rd_count), 32'(vq[i].erd));
            chk({vq[i].nm, ".wr_count"}, 32'(wr_count), 32'(vq[i].ewr));
            chk({vq[i].nm, ".err"},      32'(protocol_err), 32'(vq[i].eerr));
            chk({vq[i].nm, ".busy"},     32'(busy), 32'(vq[i].ebusy));
            if (vq[i].chk_dq)
                chk({vq[i].nm, ".dq"}, dq, vq[i].edq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
